// File: rtl/chip8_mem_pkg.sv
// Shared ids, state encodings and the read-tag record used by the CHIP-8 memory arbiter.
package chip8_mem_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] REQ_DRAW  = 2'd0;
  localparam logic [1:0] REQ_DUMP  = 2'd1;
  localparam logic [1:0] REQ_FETCH = 2'd2;
  localparam logic [1:0] REQ_NONE  = 2'd3;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic       vld;
    logic [1:0] id;
  } rd_tag_t;
endpackage

// File: rtl/rd_tag_pipe.sv
// Delays the {valid, requester id} of each read issue by the memory latency.
module rd_tag_pipe
  import chip8_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t issue,
  output rd_tag_t ret,
  output logic    empty
);
  logic [DEPTH:1]      vld_pipe;
  logic [DEPTH:1][1:0] id_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[1] <= issue.vld;
      id_pipe[1]  <= issue.id;
      for (int i = 2; i <= DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  assign ret   = '{vld: vld_pipe[DEPTH], id: id_pipe[DEPTH]};
  assign empty = ~|vld_pipe;
endmodule

// File: rtl/mem_arbiter.sv
// Shares the CHIP-8 memory read port among draw/dump/fetch and gates the write port by boot mode.
module mem_arbiter
  import chip8_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_W_DEF,
  parameter int DATA_WIDTH  = DATA_W_DEF,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  boot_start,
  input  logic                  boot_done,
  output logic                  boot_o,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_d,
  input  logic                  op_we,
  input  logic [ADDR_WIDTH-1:0] op_addr,
  input  logic [DATA_WIDTH-1:0] op_d,
  input  logic                  draw_req,
  input  logic                  draw_lock,
  input  logic [ADDR_WIDTH-1:0] draw_addr,
  input  logic                  dump_req,
  input  logic                  dump_lock,
  input  logic [ADDR_WIDTH-1:0] dump_addr,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  draw_gnt,
  output logic                  dump_gnt,
  output logic                  fetch_gnt,
  output logic                  draw_rvalid,
  output logic                  dump_rvalid,
  output logic                  fetch_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_d,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  wr_err
);
  logic [1:0]                 state, lock_owner, gnt_id;
  logic [2:0]                 req, lock;
  logic [2:0][ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0]      raddr_q;
  logic                       boot, pipe_empty;
  rd_tag_t                    issue, ret;

  assign req  = {fetch_req, dump_req, draw_req};
  assign lock = {1'b0, dump_lock, draw_lock};
  assign addr = {fetch_addr, dump_addr, draw_addr};
  assign boot = (state == ST_BOOT);

  // A held lock blocks everyone else outright, even higher-priority requesters.
  always_comb begin
    gnt_id = REQ_NONE;
    if (state == ST_RUN) begin
      if (lock_owner != REQ_NONE) gnt_id = req[lock_owner] ? lock_owner : REQ_NONE;
      else if (req[REQ_DRAW])     gnt_id = REQ_DRAW;
      else if (req[REQ_DUMP])     gnt_id = REQ_DUMP;
      else if (req[REQ_FETCH])    gnt_id = REQ_FETCH;
    end
  end

  assign issue     = '{vld: gnt_id != REQ_NONE, id: gnt_id};
  assign draw_gnt  = (gnt_id == REQ_DRAW);
  assign dump_gnt  = (gnt_id == REQ_DUMP);
  assign fetch_gnt = (gnt_id == REQ_FETCH);
  assign mem_raddr = issue.vld ? addr[gnt_id] : raddr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BOOT;
      lock_owner <= REQ_NONE;
      raddr_q    <= '0;
      wr_err     <= 1'b0;
    end else begin
      raddr_q <= mem_raddr;
      if (boot ? op_we : ld_we) wr_err <= 1'b1;
      if (issue.vld)
        lock_owner <= lock[gnt_id] ? gnt_id : REQ_NONE;
      else if (lock_owner != REQ_NONE && !req[lock_owner])
        lock_owner <= REQ_NONE;
      case (state)
        ST_BOOT:  if (boot_done) state <= ST_RUN;
        ST_RUN:   if (boot_start) state <= ST_DRAIN;
        ST_DRAIN: if (lock_owner == REQ_NONE && pipe_empty) state <= ST_BOOT;
        default:  state <= ST_BOOT;
      endcase
    end
  end

  rd_tag_pipe #(.DEPTH(MEM_LATENCY)) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .issue (issue),
    .ret   (ret),
    .empty (pipe_empty)
  );

  assign draw_rvalid  = ret.vld && (ret.id == REQ_DRAW);
  assign dump_rvalid  = ret.vld && (ret.id == REQ_DUMP);
  assign fetch_rvalid = ret.vld && (ret.id == REQ_FETCH);
  assign rdata        = mem_q;

  // Loader owns the write port only in BOOT; BCD stores own it otherwise.
  assign mem_we    = boot ? ld_we   : op_we;
  assign mem_waddr = boot ? ld_addr : op_addr;
  assign mem_d     = boot ? ld_d    : op_d;
  assign boot_o    = boot;
endmodule
